// File: rtl/exp1_button_cond_if.sv
// Button-conditioner signal bundle for the traffic countdown experiment.
//   key_up_n, key_dn_n : raw active-low push-buttons (asynchronous to clk_16)
//   repeat_en          : 1 = auto-repeat enabled while a button is held
//   up_pulse, dn_pulse : one-cycle count commands towards the countdown core
//   up_held, dn_held   : debounced pressed level per channel
// master = board/consumer side, slave = the conditioner.
interface exp1_button_cond_if;
    logic key_up_n;
    logic key_dn_n;
    logic repeat_en;
    logic up_pulse;
    logic dn_pulse;
    logic up_held;
    logic dn_held;

    modport master (
        output key_up_n, key_dn_n, repeat_en,
        input  up_pulse, dn_pulse, up_held, dn_held
    );

    modport slave (
        input  key_up_n, key_dn_n, repeat_en,
        output up_pulse, dn_pulse, up_held, dn_held
    );
endinterface

// File: rtl/exp1_button_cond.sv
// Two-channel push-button conditioner: synchronise, debounce press and
// release, emit one pulse per confirmed press and optional auto-repeat.
//   clk_16 : system clock
//   rst_n  : asynchronous active-low reset
//   btn    : exp1_button_cond_if.slave (keys and repeat_en in; pulses and
//            held levels out). Channel 0 = up, channel 1 = down.
module exp1_button_cond #(
    parameter logic [23:0] DB_CYCLES    = 24'd160000,
    parameter logic [23:0] REPEAT_DELAY = 24'd8000000,
    parameter logic [23:0] REPEAT_RATE  = 24'd1600000
) (
    input logic               clk_16,
    input logic               rst_n,
    exp1_button_cond_if.slave btn
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_HELD,
        S_REPEAT,
        S_RELEASE
    } state_t;

    localparam logic [23:0] DELAY_LAST = REPEAT_DELAY - 24'd1;
    localparam logic [23:0] RATE_LAST  = REPEAT_RATE - 24'd1;

    logic [1:0] key_raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] pulse_q;
    logic [1:0] held_q;
    logic       repeat_mask;

    assign key_raw = {btn.key_dn_n, btn.key_up_n};

    always_ff @(posedge clk_16 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    // Both channels held: repeats are suppressed, counters keep running.
    assign repeat_mask = held_q[0] & held_q[1];

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        state_t      state_q, state_d;
        logic [23:0] cnt_q, cnt_d;
        logic        p_q, p_d;
        logic        h_q, h_d;
        logic        key_s;

        assign key_s = sync2_q[ch];

        always_ff @(posedge clk_16 or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                p_q     <= 1'b0;
                h_q     <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                p_q     <= p_d;
                h_q     <= h_d;
            end
        end

        // The counter holds the number of consecutive debounce samples already
        // seen; a press/release is confirmed on the sample that makes it reach
        // DB_CYCLES. IDLE shares the PRESS path since its counter is 0, which
        // also makes DB_CYCLES == 1 confirm on the first low sample.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            p_d     = 1'b0;
            h_d     = h_q;
            case (state_q)
                S_IDLE, S_PRESS: begin
                    if (key_s) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q + 24'd1 == DB_CYCLES) begin
                        p_d     = 1'b1;
                        h_d     = 1'b1;
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_PRESS;
                        cnt_d   = cnt_q + 24'd1;
                    end
                end
                S_HELD, S_REPEAT: begin
                    if (key_s) begin
                        if (DB_CYCLES == 24'd1) begin
                            state_d = S_IDLE;
                            h_d     = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_RELEASE;
                            cnt_d   = 24'd1;
                        end
                    end else if (state_q == S_HELD) begin
                        if (cnt_q == DELAY_LAST) begin
                            // Saturated here until repeat_en allows the first repeat.
                            if (btn.repeat_en) begin
                                p_d     = ~repeat_mask;
                                state_d = S_REPEAT;
                                cnt_d   = '0;
                            end
                        end else begin
                            cnt_d = cnt_q + 24'd1;
                        end
                    end else if (!btn.repeat_en) begin
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == RATE_LAST) begin
                        p_d   = ~repeat_mask;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                S_RELEASE: begin
                    if (!key_s) begin
                        // Bounce during release: back to held, not a new press.
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q + 24'd1 == DB_CYCLES) begin
                        state_d = S_IDLE;
                        h_d     = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    h_d     = 1'b0;
                end
            endcase
        end

        assign pulse_q[ch] = p_q;
        assign held_q[ch]  = h_q;
    end

    assign btn.up_pulse = pulse_q[0];
    assign btn.dn_pulse = pulse_q[1];
    assign btn.up_held  = held_q[0];
    assign btn.dn_held  = held_q[1];

endmodule

// File: tb/tb_exp1_button_cond.sv
// Testbench for exp1_button_cond with DB_CYCLES = 4, REPEAT_DELAY = 10,
// REPEAT_RATE = 3. A behavioural model tracks run lengths of synchronised
// key samples and elapsed time since the last pulse/anchor per channel.
module tb_exp1_button_cond;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic clk_16 = 1'b0;
    logic rst_n  = 1'b0;

    exp1_button_cond_if btn ();

    exp1_button_cond #(
        .DB_CYCLES   (24'(DB)),
        .REPEAT_DELAY(24'(RD)),
        .REPEAT_RATE (24'(RR))
    ) dut (
        .clk_16(clk_16),
        .rst_n (rst_n),
        .btn   (btn)
    );

    always #5 clk_16 = ~clk_16;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural reference model state.
    int cyc;
    int lo_run [2];
    int hi_run [2];
    int anchor [2];
    bit in_rep [2];
    bit held_m [2];
    bit pulse_m[2];
    bit d1     [2];
    bit d2     [2];

    logic [3:0] obs;
    logic [3:0] exp_v;
    assign obs   = {btn.up_pulse, btn.dn_pulse, btn.up_held, btn.dn_held};
    assign exp_v = {pulse_m[0], pulse_m[1], held_m[0], held_m[1]};

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            lo_run[ch]  = 0;
            hi_run[ch]  = 0;
            anchor[ch]  = 0;
            in_rep[ch]  = 1'b0;
            held_m[ch]  = 1'b0;
            pulse_m[ch] = 1'b0;
            d1[ch]      = 1'b1;
            d2[ch]      = 1'b1;
        end
    endtask

    initial begin : model
        bit raw [2];
        bit s;
        bit mask;
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk_16 or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                raw[0] = btn.key_up_n;
                raw[1] = btn.key_dn_n;
                mask   = held_m[0] && held_m[1];
                for (int ch = 0; ch < 2; ch++) begin
                    s = d2[ch];
                    pulse_m[ch] = 1'b0;
                    if (!held_m[ch]) begin
                        if (!s) begin
                            lo_run[ch]++;
                            if (lo_run[ch] == DB) begin
                                pulse_m[ch] = 1'b1;
                                held_m[ch]  = 1'b1;
                                lo_run[ch]  = 0;
                                hi_run[ch]  = 0;
                                in_rep[ch]  = 1'b0;
                                anchor[ch]  = cyc;
                            end
                        end else begin
                            lo_run[ch] = 0;
                        end
                    end else if (s) begin
                        hi_run[ch]++;
                        in_rep[ch] = 1'b0;
                        if (hi_run[ch] == DB) begin
                            held_m[ch] = 1'b0;
                            hi_run[ch] = 0;
                            lo_run[ch] = 0;
                        end
                    end else if (hi_run[ch] > 0) begin
                        hi_run[ch] = 0;
                        in_rep[ch] = 1'b0;
                        anchor[ch] = cyc;
                    end else if (!in_rep[ch]) begin
                        if (btn.repeat_en && (cyc - anchor[ch] >= RD)) begin
                            pulse_m[ch] = !mask;
                            in_rep[ch]  = 1'b1;
                            anchor[ch]  = cyc;
                        end
                    end else if (!btn.repeat_en) begin
                        in_rep[ch] = 1'b0;
                        anchor[ch] = cyc;
                    end else if (cyc - anchor[ch] == RR) begin
                        pulse_m[ch] = !mask;
                        anchor[ch]  = cyc;
                    end
                    d2[ch] = d1[ch];
                    d1[ch] = raw[ch];
                end
                cyc++;
            end
        end
    end

    task automatic test_reset();
        btn.key_up_n  = 1'b1;
        btn.key_dn_n  = 1'b1;
        btn.repeat_en = 1'b0;
        rst_n         = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_16);
            if (k == 0) begin
                vectors++;
                if (obs !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL reset_state: got %b want 0000", obs);
                end
            end
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_model k=%0d: got %b want %b", k, obs, exp_v);
            end
            if (k == 3) rst_n = 1'b1;
        end
    endtask

    task automatic test_clean_press();
        int n_up = 0, n_dn = 0, pulse_at = -1, drop_at = -1, held_bad = 0;
        btn.repeat_en = 1'b0;
        btn.key_up_n  = 1'b0;
        for (int k = 0; k < 52; k++) begin
            @(negedge clk_16);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL clean_press k=%0d: got %b want %b", k, obs, exp_v);
            end
            if (btn.up_pulse) begin n_up++; pulse_at = k; end
            if (btn.dn_pulse) n_dn++;
            if (k >= 5 && k < 45 && !btn.up_held) held_bad++;
            if (k >= 40 && !btn.up_held && drop_at < 0) drop_at = k - 40;
            if (k == 39) btn.key_up_n = 1'b1;
        end
        vectors++;
        if (n_up != 1 || pulse_at != 5) begin
            miscompares++;
            $display("FAIL clean_press_pulse: got count %0d at %0d want count 1 at 5", n_up, pulse_at);
        end
        vectors++;
        if (n_dn != 0 || held_bad != 0) begin
            miscompares++;
            $display("FAIL clean_press_side: got dn pulses %0d held gaps %0d want 0 0", n_dn, held_bad);
        end
        vectors++;
        if (drop_at != DB + 1) begin
            miscompares++;
            $display("FAIL clean_release: got held drop at %0d want %0d", drop_at, DB + 1);
        end
    endtask

    task automatic test_glitch();
        int n_dn = 0, held_seen = 0;
        btn.repeat_en = 1'b0;
        btn.key_dn_n  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_16);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL glitch k=%0d: got %b want %b", k, obs, exp_v);
            end
            if (btn.dn_pulse) n_dn++;
            if (btn.dn_held) held_seen++;
            if (k == 2) btn.key_dn_n = 1'b1;
        end
        vectors++;
        if (n_dn != 0 || held_seen != 0) begin
            miscompares++;
            $display("FAIL glitch_reject: got pulses %0d held %0d want 0 0", n_dn, held_seen);
        end
    endtask

    task automatic test_repeat();
        bit want;
        int n_up = 0, n_win = 0, held_bad = 0;
        btn.repeat_en = 1'b1;
        btn.key_up_n  = 1'b0;
        for (int k = 0; k < 42; k++) begin
            @(negedge clk_16);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL repeat k=%0d: got %b want %b", k, obs, exp_v);
            end
            want = (k == 5) || (k >= 5 + RD && k <= 30 && ((k - 5 - RD) % RR) == 0);
            vectors++;
            if (btn.up_pulse !== want) begin
                miscompares++;
                $display("FAIL repeat_sched k=%0d: got %b want %b", k, btn.up_pulse, want);
            end
            if (k == 29) btn.key_up_n = 1'b1;
        end
        // Second hold with a two-cycle high bounce in the middle.
        btn.key_up_n = 1'b0;
        for (int k = 0; k < 62; k++) begin
            @(negedge clk_16);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL bounce k=%0d: got %b want %b", k, obs, exp_v);
            end
            if (btn.up_pulse) n_up++;
            if (btn.up_pulse && k >= 22 && k <= 33) n_win++;
            if (k >= 5 && k <= 54 && !btn.up_held) held_bad++;
            if (k == 19) btn.key_up_n = 1'b1;
            if (k == 21) btn.key_up_n = 1'b0;
            if (k == 49) btn.key_up_n = 1'b1;
        end
        vectors++;
        if (n_win != 0 || held_bad != 0 || n_up != 10) begin
            miscompares++;
            $display("FAIL bounce_hold: got window %0d gaps %0d total %0d want 0 0 10", n_win, held_bad, n_up);
        end
    endtask

    task automatic test_conflict();
        int up_masked = 0, up_resume = 0, n_dn = 0, dn_at = -1;
        btn.repeat_en = 1'b1;
        btn.key_up_n  = 1'b0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk_16);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL conflict k=%0d: got %b want %b", k, obs, exp_v);
            end
            if (btn.up_pulse && k >= 6 && k <= 45) up_masked++;
            if (btn.up_pulse && k >= 46 && k <= 56) up_resume++;
            if (btn.dn_pulse) begin n_dn++; dn_at = k; end
            if (k == 7)  btn.key_dn_n = 1'b0;
            if (k == 39) btn.key_dn_n = 1'b1;
            if (k == 54) btn.key_up_n = 1'b1;
        end
        vectors++;
        if (up_masked != 0 || up_resume != 3) begin
            miscompares++;
            $display("FAIL conflict_up: got masked %0d resumed %0d want 0 3", up_masked, up_resume);
        end
        vectors++;
        if (n_dn != 1 || dn_at != 13) begin
            miscompares++;
            $display("FAIL conflict_dn: got count %0d at %0d want 1 at 13", n_dn, dn_at);
        end
    endtask

    task automatic test_same_cycle();
        int both_at = -1, diff = 0, n_up = 0;
        btn.repeat_en = 1'b0;
        btn.key_up_n  = 1'b0;
        btn.key_dn_n  = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_16);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL same_cycle k=%0d: got %b want %b", k, obs, exp_v);
            end
            if (btn.up_pulse !== btn.dn_pulse) diff++;
            if (btn.up_pulse && btn.dn_pulse) both_at = k;
            if (btn.up_pulse) n_up++;
            if (k == 9) begin
                btn.key_up_n = 1'b1;
                btn.key_dn_n = 1'b1;
            end
        end
        vectors++;
        if (both_at != 5 || diff != 0 || n_up != 1) begin
            miscompares++;
            $display("FAIL same_cycle_pulse: got at %0d diff %0d count %0d want 5 0 1", both_at, diff, n_up);
        end
    endtask

    task automatic test_reset_mid();
        int n_up = 0, pulse_at = -1;
        btn.repeat_en = 1'b1;
        btn.key_up_n  = 1'b0;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk_16);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_mid_pre k=%0d: got %b want %b", k, obs, exp_v);
            end
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid_clear: got %b want 0000", obs);
        end
        btn.repeat_en = 1'b0;
        @(negedge clk_16);
        @(negedge clk_16);
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk_16);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_mid_post k=%0d: got %b want %b", k, obs, exp_v);
            end
            if (btn.up_pulse) begin n_up++; pulse_at = k; end
            if (k == 19) btn.key_up_n = 1'b1;
        end
        vectors++;
        if (n_up != 1 || pulse_at != 5) begin
            miscompares++;
            $display("FAIL reset_mid_repress: got count %0d at %0d want 1 at 5", n_up, pulse_at);
        end
    endtask

    task automatic test_random();
        int run [2];
        run[0] = 0;
        run[1] = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk_16);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL random k=%0d: got %b want %b", k, obs, exp_v);
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (run[ch] == 0) begin
                    run[ch] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6))
                                                          : int'($urandom_range(8, 40));
                    if (ch == 0) btn.key_up_n = ~btn.key_up_n;
                    else         btn.key_dn_n = ~btn.key_dn_n;
                end else begin
                    run[ch]--;
                end
            end
            if ($urandom_range(0, 39) == 0) btn.repeat_en = ~btn.repeat_en;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_repeat();
        test_conflict();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
